// File: rtl/snd_cmd_mailbox.sv
// Command mailbox from main CPU to sound CPU (single latch or FIFO) with sound-CPU
// interrupt, sticky overflow, and a reply register for readback in the other direction.
module snd_cmd_mailbox #(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 4,
  parameter int                MODE      = 1,
  parameter int                IRQ_LEVEL = 0,
  parameter logic [DATA_W-1:0] REPLY_RST = 8'hFF
) (
  input  logic                       clk_49m,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          cmd_in,
  input  logic                       cmd_wr,
  input  logic                       snd_rd,
  input  logic                       irq_ack,
  output logic [DATA_W-1:0]          cmd_out,
  output logic                       pending,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       snd_irq,
  input  logic [DATA_W-1:0]          reply_in,
  input  logic                       reply_wr,
  output logic [DATA_W-1:0]          reply_out
);

  localparam int CW = $clog2(DEPTH+1);

  logic acc_wr;
  logic pend_nxt;

  generate
    if (MODE == 0) begin : g_latch
      always_comb begin
        acc_wr   = cmd_wr;
        pend_nxt = cmd_wr || (pending && !snd_rd);
      end

      always_ff @(posedge clk_49m) begin
        if (reset) begin
          cmd_out  <= '0;
          pending  <= 1'b0;
          full     <= 1'b0;
          count    <= '0;
          overflow <= 1'b0;
        end else begin
          if (cmd_wr) cmd_out <= cmd_in;
          pending <= pend_nxt;
          full    <= pend_nxt;
          count   <= CW'(pend_nxt);
          if (cmd_wr && pending && !snd_rd) overflow <= 1'b1;
        end
      end
    end else begin : g_fifo
      localparam int PW = $clog2(DEPTH);

      logic [DATA_W-1:0] mem [DEPTH];
      logic [PW-1:0]     wr_ptr;
      logic [PW-1:0]     rd_ptr;
      logic [PW-1:0]     rd_ptr_nxt;
      logic [CW-1:0]     cnt_nxt;
      logic              rd_en;

      // When full, a simultaneous pop frees the slot the write lands in.
      always_comb begin
        acc_wr     = cmd_wr && (!full || snd_rd);
        rd_en      = snd_rd && (count != '0);
        rd_ptr_nxt = rd_en ? PW'(rd_ptr + 1'b1) : rd_ptr;
        cnt_nxt    = count;
        if (acc_wr && !rd_en)      cnt_nxt = count + 1'b1;
        else if (!acc_wr && rd_en) cnt_nxt = count - 1'b1;
        pend_nxt   = (cnt_nxt != '0);
      end

      always_ff @(posedge clk_49m) begin
        if (!reset && acc_wr) mem[wr_ptr] <= cmd_in;
      end

      always_ff @(posedge clk_49m) begin
        if (reset) begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          cmd_out  <= '0;
          pending  <= 1'b0;
          full     <= 1'b0;
          count    <= '0;
          overflow <= 1'b0;
        end else begin
          if (acc_wr) wr_ptr <= PW'(wr_ptr + 1'b1);
          rd_ptr  <= rd_ptr_nxt;
          count   <= cnt_nxt;
          pending <= pend_nxt;
          full    <= (cnt_nxt == CW'(DEPTH));
          if (cmd_wr && full && !snd_rd) overflow <= 1'b1;
          // The new head may be the word being written this very cycle.
          if (pend_nxt)
            cmd_out <= (acc_wr && (wr_ptr == rd_ptr_nxt)) ? cmd_in : mem[rd_ptr_nxt];
        end
      end
    end
  endgenerate

  generate
    if (IRQ_LEVEL == 0) begin : g_irq_sticky
      always_ff @(posedge clk_49m) begin
        if (reset)        snd_irq <= 1'b0;
        else if (acc_wr)  snd_irq <= 1'b1;
        else if (irq_ack) snd_irq <= 1'b0;
      end
    end else begin : g_irq_level
      logic unused_irq_ack;
      assign unused_irq_ack = irq_ack;

      always_ff @(posedge clk_49m) begin
        if (reset) snd_irq <= 1'b0;
        else       snd_irq <= pend_nxt;
      end
    end
  endgenerate

  always_ff @(posedge clk_49m) begin
    if (reset)         reply_out <= REPLY_RST;
    else if (reply_wr) reply_out <= reply_in;
  end

endmodule
